ar_ambiente: RTL
================

Name: ar_ambiente

Overview:
- Room/plant model at the other end of the air-conditioner controller interface.
- Consumes the controller's actuator commands (cool/heat) and produces the measured room temperature ("real") and the condensation-drip flag ("pingando") that the controller reads back.
- Closes the loop on the board, so the controller can be exercised with SWI/LED only, without external hardware.

Parameters:
TEMP_BITS, 3, width of temperature value; range 0..2^TEMP_BITS-1
AMBIENT, 5, temperature the room drifts to when no command is active
TEMP_RESET, 5, value of real after reset
STEP_CYCLES, 4, clock cycles per 1-degree step while cooling/heating (>=1)
DRIFT_CYCLES, 8, clock cycles per 1-degree step while drifting (>=1)
DRIP_CYCLES, 16, continuous cooling cycles needed to assert pingando (>=1)

Ports:
clk_2  in  1  single clock
reset  in  1  synchronous, active-high
resfriar  in  1  cooling command from controller
aquecer  in  1  heating command from controller
real  out  TEMP_BITS  current room temperature, registered
muda  out  1  one-cycle pulse, high in the cycle real shows a new value
pingando  out  1  drip flag, registered
estado  out  2  current state: 00 PARADO, 01 RESFRIANDO, 10 AQUECENDO, 11 DERIVA

Behaviour:
- Reset (sync, active-high, priority over everything):
  - real=TEMP_RESET, estado=PARADO, muda=0, pingando=0.
  - Step counter and drip counter cleared to 0.
  - Reset asserted mid-step or mid-drip aborts the operation; no partial step survives.
- Next-state rule, evaluated every cycle and registered (1-cycle command latency):
  - resfriar&~aquecer -> RESFRIANDO
  - aquecer&~resfriar -> AQUECENDO
  - otherwise: real!=AMBIENT -> DERIVA, else PARADO
  - resfriar&aquecer (illegal) is treated as no command.
- Step counter:
  - Clears to 0 on the edge where the state changes.
  - Otherwise counts up in RESFRIANDO/AQUECENDO/DERIVA; held at 0 in PARADO.
  - Period P: STEP_CYCLES in RESFRIANDO/AQUECENDO, DRIFT_CYCLES in DERIVA.
  - In a cycle with counter==P-1: counter wraps to 0 and a step is applied at that edge.
- Step:
  - RESFRIANDO: real-1, saturating at 0.
  - AQUECENDO: real+1, saturating at 2^TEMP_BITS-1.
  - DERIVA: one step toward AMBIENT.
- muda is registered together with real: high exactly in the cycle after a step that changed real.
  - A saturated step (no change) gives muda=0; the counter keeps running.
- DERIVA reaching AMBIENT: the next-state rule moves the state to PARADO on the following edge; the counter clears.
- Drip counter (0..DRIP_CYCLES):
  - +1 per cycle while registered estado==RESFRIANDO, saturating at DRIP_CYCLES.
  - -1 per cycle in any other state, saturating at 0.
- pingando (hysteresis):
  - Set on the edge the drip counter becomes DRIP_CYCLES.
  - Cleared on the edge it becomes 0.
  - Unchanged otherwise.
- All outputs are registers; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold reset 2 cycles -> real=5, estado=00, muda=0, pingando=0; with no commands, estado stays 00 indefinitely.
- Cooling to floor: resfriar=1 from the edge after reset.
  - estado=01 after edge 1.
  - real = 4,3,2,1,0 after edges 5,9,13,17,21; muda high in exactly those 5 cycles.
  - real stays 0 afterwards with no further muda pulses.
- Drip: continue the previous run -> pingando rises after edge 17.
  - Drop resfriar at edge 30: estado=11 after edge 31.
  - pingando stays 1 until the drip counter drains; it falls 16 cycles after cooling stopped.
  - real drifts 0->5 at one step per 8 cycles (5 muda pulses); estado=00 the edge after real reaches 5.
- Heating to ceiling: aquecer=1 from reset -> real=6 after edge 5, real=7 after edge 9; saturates at 7 with no further muda pulses; pingando stays 0.
- Illegal command: resfriar=aquecer=1 with real=5 -> estado=00, real unchanged for 50 cycles; the same with real=3 -> estado=11, drift upward to 5.
- Reset mid-operation: assert reset while estado=01, counter=2, drip counter=10 -> next cycle all outputs at reset values; pingando=0; a fresh cooling command needs a full 4 cycles for the first step.

Source files
------------

// File: rtl/ar_ambiente.sv
// Room/plant model: turns the A/C controller's cool/heat commands into a room temperature and a drip flag.
// Latency: commands take effect on the next edge; temperature steps every STEP_CYCLES (DRIFT_CYCLES when drifting).
// Backpressure: none, the commands are sampled every cycle and every output is a register.
//
// Ports:
//   clk_2      single clock
//   reset      synchronous, active-high; has priority over everything else
//   resfriar   cooling command from the controller
//   aquecer    heating command from the controller (both high together is treated as no command)
//   real_temp  current room temperature, registered. `real` is a reserved word, hence the longer name.
//   muda       one-cycle pulse, high in the cycle real_temp shows a new value
//   pingando   condensation drip flag with hysteresis, registered
//   estado     current state: 00 PARADO, 01 RESFRIANDO, 10 AQUECENDO, 11 DERIVA
module ar_ambiente #(
  parameter int TEMP_BITS    = 3,
  parameter int AMBIENT      = 5,
  parameter int TEMP_RESET   = 5,
  parameter int STEP_CYCLES  = 4,
  parameter int DRIFT_CYCLES = 8,
  parameter int DRIP_CYCLES  = 16
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 resfriar,
  input  logic                 aquecer,
  output logic [TEMP_BITS-1:0] real_temp,
  output logic                 muda,
  output logic                 pingando,
  output logic [1:0]           estado
);

  typedef enum logic [1:0] {
    PARADO     = 2'b00,
    RESFRIANDO = 2'b01,
    AQUECENDO  = 2'b10,
    DERIVA     = 2'b11
  } state_t;

  localparam int MAXP = (STEP_CYCLES > DRIFT_CYCLES) ? STEP_CYCLES : DRIFT_CYCLES;
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam int DW   = $clog2(DRIP_CYCLES + 1);

  localparam logic [TEMP_BITS-1:0] T_MAX = '1;
  localparam logic [TEMP_BITS-1:0] T_AMB = TEMP_BITS'(AMBIENT);
  localparam logic [TEMP_BITS-1:0] T_RST = TEMP_BITS'(TEMP_RESET);
  localparam logic [TEMP_BITS-1:0] T_ONE = TEMP_BITS'(1);
  localparam logic [CW-1:0]        STEP_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0]        DRIFT_LAST = CW'(DRIFT_CYCLES - 1);
  localparam logic [CW-1:0]        C_ONE      = CW'(1);
  localparam logic [DW-1:0]        DRIP_MAX   = DW'(DRIP_CYCLES);
  localparam logic [DW-1:0]        D_ONE      = DW'(1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, period_last;
  logic [DW-1:0]        drip_q, drip_d;
  logic [TEMP_BITS-1:0] temp_q, temp_d;
  logic                 step_en;

  // Next state: an illegal cool+heat request falls through to the no-command branch.
  always_comb begin
    state_d = PARADO;
    if (resfriar && !aquecer) begin
      state_d = RESFRIANDO;
    end else if (aquecer && !resfriar) begin
      state_d = AQUECENDO;
    end else if (temp_q != T_AMB) begin
      state_d = DERIVA;
    end
  end

  // Step counter: a state change restarts the period, so a step is only ever
  // applied after a full period spent in one state.
  always_comb begin
    cnt_d       = '0;
    step_en     = 1'b0;
    period_last = (state_q == DERIVA) ? DRIFT_LAST : STEP_LAST;
    if (state_d == state_q && state_q != PARADO) begin
      if (cnt_q == period_last) begin
        step_en = 1'b1;
      end else begin
        cnt_d = cnt_q + C_ONE;
      end
    end
  end

  // Temperature step, saturating at both ends; drift moves toward ambient.
  always_comb begin
    temp_d = temp_q;
    if (step_en) begin
      case (state_q)
        RESFRIANDO: if (temp_q != '0)    temp_d = temp_q - T_ONE;
        AQUECENDO:  if (temp_q != T_MAX) temp_d = temp_q + T_ONE;
        DERIVA: begin
          if (temp_q < T_AMB)      temp_d = temp_q + T_ONE;
          else if (temp_q > T_AMB) temp_d = temp_q - T_ONE;
        end
        default: temp_d = temp_q;
      endcase
    end
  end

  // Drip accumulator follows the registered state, not the command.
  always_comb begin
    drip_d = drip_q;
    if (state_q == RESFRIANDO) begin
      if (drip_q != DRIP_MAX) drip_d = drip_q + D_ONE;
    end else if (drip_q != '0) begin
      drip_d = drip_q - D_ONE;
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q  <= PARADO;
      cnt_q    <= '0;
      drip_q   <= '0;
      temp_q   <= T_RST;
      muda     <= 1'b0;
      pingando <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drip_q  <= drip_d;
      temp_q  <= temp_d;
      muda    <= (temp_d != temp_q);
      // Hysteresis: set only at full, clear only at empty.
      if (drip_d == DRIP_MAX) begin
        pingando <= 1'b1;
      end else if (drip_d == '0) begin
        pingando <= 1'b0;
      end
    end
  end

  assign real_temp = temp_q;
  assign estado    = state_q;

endmodule
